// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider
//   Sequential radix-2 restoring divider: unsigned DW-bit dividend divided by
//   an unsigned VW-bit divisor, one quotient bit per clock, valid/ready on the
//   input and output sides. Used to divide a multiplier product back by one
//   operand when characterising multiplier errors.
//
//   Optional feature (macro DIV_EARLY_EXIT_EN):
//     defined   - divisor == 0 or dividend < divisor finishes after a single
//                 CALC cycle instead of DW cycles; results are unchanged.
//     undefined - every operation spends DW cycles in CALC.

module seq_restoring_divider #(
    parameter int DW = 16,
    parameter int VW = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    // One extra bit so the counter can represent DW itself.
    localparam int CW = $clog2(DW) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t        state_q, state_d;

    // Working datapath: loaded on accept, so it needs no reset.
    logic [DW-1:0] work_q, work_d;       // dividend bits shift out, quotient bits shift in
    logic [VW:0]   part_q, part_d;       // partial remainder, one bit wider than the divisor
    logic [VW-1:0] dvs_q, dvs_d;         // captured divisor
    logic [VW-1:0] dvd_lo_q, dvd_lo_d;   // captured dividend LSBs for the short-cut results
    logic [CW-1:0] cnt_q, cnt_d;         // iteration counter
    logic          early_q, early_d;     // operation finishes after one CALC cycle

    // Result registers: visible on the outputs, cleared by reset.
    logic [DW-1:0] quot_q, quot_d;
    logic [VW-1:0] rem_q, rem_d;
    logic          dbz_q, dbz_d;

    logic [VW:0]   trial;
    logic [VW:0]   trial_sub;
    logic          q_bit;
    logic          early;

    // Shift the next dividend bit into the partial remainder and try a subtract.
    // The partial remainder is always below the divisor, so its top bit is
    // zero before the shift and nothing is lost.
    assign trial     = {part_q[VW-1:0], work_q[DW-1]};
    assign trial_sub = trial - {1'b0, dvs_q};
    assign q_bit     = (trial >= {1'b0, dvs_q});

`ifdef DIV_EARLY_EXIT_EN
    assign early = (divisor == '0) || (DW'(divisor) > dividend);
`else
    assign early = 1'b0;
`endif

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

    // Next-state, datapath update and handshake outputs.
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        part_d    = part_q;
        dvs_d     = dvs_q;
        dvd_lo_d  = dvd_lo_q;
        cnt_d     = cnt_q;
        early_d   = early_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        dbz_d     = dbz_q;
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    work_d   = dividend;
                    part_d   = '0;
                    dvs_d    = divisor;
                    dvd_lo_d = dividend[VW-1:0];
                    cnt_d    = '0;
                    early_d  = early;
                    state_d  = S_CALC;
                end
            end

            S_CALC: begin
                if (early_q) begin
                    // Short cut: either divide-by-zero or a zero quotient.
                    state_d = S_DONE;
                    quot_d  = (dvs_q == '0) ? '1 : '0;
                    rem_d   = dvd_lo_q;
                    dbz_d   = (dvs_q == '0);
                end else begin
                    work_d = {work_q[DW-2:0], q_bit};
                    part_d = q_bit ? trial_sub : trial;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == CW'(DW - 1)) begin
                        state_d = S_DONE;
                        if (dvs_q == '0) begin
                            // The iteration still ran; its result is replaced here.
                            quot_d = '1;
                            rem_d  = dvd_lo_q;
                            dbz_d  = 1'b1;
                        end else begin
                            quot_d = {work_q[DW-2:0], q_bit};
                            rem_d  = part_d[VW-1:0];
                            dbz_d  = 1'b0;
                        end
                    end
                end
            end

            S_DONE: begin
                // Results stay frozen until the consumer takes them.
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    // Working datapath registers, always loaded on accept before use.
    // NOTE: these carry no reset; their contents are never observed before an accept overwrites them.
    always_ff @(posedge CLK) begin
        work_q   <= work_d;
        part_q   <= part_d;
        dvs_q    <= dvs_d;
        dvd_lo_q <= dvd_lo_d;
        cnt_q    <= cnt_d;
        early_q  <= early_d;
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider
//   Self-checking bench: directed cases with hand-computed results, then a
//   randomized sweep with random input gaps and output back-pressure, all
//   compared against a behavioural divide model held in a queue.

module tb_seq_restoring_divider;

    localparam int DW = 16;
    localparam int VW = 8;
    localparam int N_RANDOM = 2000;

`ifdef DIV_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic          CLK;
    logic          RST;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;

    seq_restoring_divider #(.DW(DW), .VW(VW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    int n_sent   = 0;
    int n_push   = 0;
    int n_pop    = 0;
    int n_abort  = 0;
    bit rnd_done = 1'b0;

    typedef struct {
        logic [DW-1:0] a;
        logic [VW-1:0] b;
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          z;
        int            due;
        bit            seen;
        bit            late;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Behavioural model: plain integer division plus the divide-by-zero rule.
    function automatic exp_t model(input logic [DW-1:0] a, input logic [VW-1:0] b, input int acc_edge);
        exp_t e;
        bit   short_op;
        e.a    = a;
        e.b    = b;
        e.seen = 1'b0;
        e.late = 1'b0;
        if (b == '0) begin
            e.q = '1;
            e.r = a[VW-1:0];
            e.z = 1'b1;
        end else begin
            e.q = a / DW'(b);
            e.r = VW'(a % DW'(b));
            e.z = 1'b0;
        end
        short_op = EARLY && ((b == '0) || (a < DW'(b)));
        e.due = acc_edge + (short_op ? 1 : DW);
        return e;
    endfunction

    // Compare process: samples mid-cycle, tracks accepts/handshakes, checks every valid cycle.
    bit rst_seen = 1'b0;
    always @(negedge CLK) begin
        if (RST) begin
            n_abort += exp_q.size();
            exp_q.delete();
            rst_seen = 1'b1;
        end else begin
            if (rst_seen) begin
                check("reset out_valid", out_valid, 0);
                check("reset quotient", quotient, 0);
                check("reset remainder", remainder, 0);
                check("reset div_by_zero", div_by_zero, 0);
                rst_seen = 1'b0;
            end
            check("in_ready vs idle", in_ready, (exp_q.size() == 0) ? 1 : 0);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected result (duplicate)");
                end else begin
                    if (!exp_q[0].seen) begin
                        check("result latency edge", cyc, exp_q[0].due);
                        exp_q[0].seen = 1'b1;
                    end
                    check("model quotient", quotient, exp_q[0].q);
                    check("model remainder", remainder, exp_q[0].r);
                    check("model div_by_zero", div_by_zero, exp_q[0].z);
                    if (exp_q[0].b != '0) begin
                        check("q*d+r == dividend",
                              longint'(quotient) * longint'(exp_q[0].b) + longint'(remainder),
                              longint'(exp_q[0].a));
                        check("remainder < divisor", (remainder < exp_q[0].b) ? 1 : 0, 1);
                    end
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        n_pop++;
                    end
                end
            end else if (exp_q.size() > 0) begin
                if (exp_q[0].seen) begin
                    fail("out_valid dropped without handshake");
                    void'(exp_q.pop_front());
                    n_pop++;
                end else if (cyc > exp_q[0].due && !exp_q[0].late) begin
                    fail("result late");
                    exp_q[0].late = 1'b1;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(dividend, divisor, cyc + 1));
                n_push++;
            end
        end
    end

    // Present an operation and hold it until accepted; returns the accept edge.
    task automatic send(input logic [DW-1:0] a, input logic [VW-1:0] b, output int e0);
        int n;
        n        = 0;
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        while (!in_ready && n < 300) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (!in_ready) fail("send: in_ready timeout");
        @(posedge CLK);
        #1;
        e0       = cyc;
        in_valid = 1'b0;
        // Scramble the inputs so a design that fails to register them shows it.
        dividend = DW'($urandom);
        divisor  = VW'($urandom);
        n_sent++;
    endtask

    // Wait for a result, compare with hand-computed literals, optionally stall, then take it.
    task automatic expect_result(input string tag, input int e0, input logic [DW-1:0] eq,
                                 input logic [VW-1:0] er, input logic ez, input int lat,
                                 input int hold);
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge CLK);
            #1;
            n++;
        end
        if (!out_valid) begin
            fail({tag, " out_valid timeout"});
            return;
        end
        check({tag, " latency"}, cyc - e0, lat);
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        check({tag, " div_by_zero"}, div_by_zero, ez);
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK);
            #1;
            check({tag, " stall out_valid"}, out_valid, 1);
            check({tag, " stall quotient"}, quotient, eq);
            check({tag, " stall remainder"}, remainder, er);
            check({tag, " stall in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge CLK);
        #1;
        out_ready = 1'b0;
        check({tag, " after handshake out_valid"}, out_valid, 0);
        check({tag, " after handshake in_ready"}, in_ready, 1);
    endtask

    initial begin
        int e0;
        int n;
        int lat_short;
        RST       = 1'b1;
        in_valid  = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b0;
        lat_short = EARLY ? 1 : DW;

        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        check("post-reset in_ready", in_ready, 1);
        check("post-reset out_valid", out_valid, 0);

        // Directed cases with hand-computed expectations.
        send(16'h3039, 8'h07, e0);
        expect_result("12345/7", e0, 16'h06E3, 8'h04, 1'b0, DW, 0);
        send(16'hFFFF, 8'hFF, e0);
        expect_result("FFFF/FF", e0, 16'h0101, 8'h00, 1'b0, DW, 0);
        send(16'hFFFF, 8'h01, e0);
        expect_result("FFFF/01", e0, 16'hFFFF, 8'h00, 1'b0, DW, 0);
        send(16'h1234, 8'h00, e0);
        expect_result("1234/00", e0, 16'hFFFF, 8'h34, 1'b1, lat_short, 0);
        send(16'h0005, 8'h09, e0);
        expect_result("5/9", e0, 16'h0000, 8'h05, 1'b0, lat_short, 0);
        send(16'hBEEF, 8'h13, e0);
        expect_result("BEEF/13 stalled", e0, 16'h0A0C, 8'h0B, 1'b0, DW, 10);

        // Reset during the fifth CALC cycle aborts the operation.
        send(16'hABCD, 8'h21, e0);
        repeat (4) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        check("abort out_valid", out_valid, 0);
        check("abort quotient", quotient, 0);
        check("abort in_ready", in_ready, 1);
        send(16'd100, 8'd9, e0);
        expect_result("100/9", e0, 16'd11, 8'd1, 1'b0, DW, 0);

        // Randomized sweep with input gaps and output back-pressure.
        fork
            begin
                for (int k = 0; k < N_RANDOM; k++) begin
                    logic [DW-1:0] a;
                    logic [VW-1:0] b;
                    int            mode;
                    repeat ($urandom_range(0, 3)) @(posedge CLK);
                    #1;
                    mode = $urandom_range(0, 9);
                    a    = DW'($urandom);
                    b    = VW'($urandom);
                    case (mode)
                        0: b = '0;
                        1: b = 8'h01;
                        2: b = 8'hFF;
                        3: a = DW'($urandom_range(0, 255));
                        4: a = '1;
                        default: ;
                    endcase
                    send(a, b, e0);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge CLK);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join

        // Drain the last result.
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge CLK);
            #1;
            n++;
        end
        @(negedge CLK);
        check("all results drained", exp_q.size(), 0);
        check("accepts match sends", n_push, n_sent);
        check("no result lost", n_pop + n_abort, n_push);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
